regs_wb_queue: RTL and testbench

//  Write-behind queue feeding the register-file write port (L_S/Wt_addr/Wt_data).

---
 rtl/regs_wb_queue.sv | 138 +++++++++++++
 tb/tb_regs_wb_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_queue.sv
// Write-behind queue in front of the register-file write port, with pending-value forwarding.
// Optional WB_BYPASS_EN: an accept into an empty queue with wb_en loads the output register directly.
module regs_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       wb_en,
  output logic                       L_S,
  output logic [AW-1:0]              Wt_addr,
  output logic [DW-1:0]              Wt_data,
  input  logic [AW-1:0]              fwd_addr_A,
  output logic                       fwd_hit_A,
  output logic [DW-1:0]              fwd_data_A,
  input  logic [AW-1:0]              fwd_addr_B,
  output logic                       fwd_hit_B,
  output logic [DW-1:0]              fwd_data_B,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          live_q;
  logic          ls_q;
  logic [AW-1:0] wt_addr_q;
  logic [DW-1:0] wt_data_q;

  logic accept, keep, pop, bypass, push;

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready = live_q && (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign keep     = accept && (in_addr != '0);
  assign pop      = wb_en && (count_q != '0);
  assign bypass   = BYPASS && keep && wb_en && (count_q == '0);
  assign push     = keep && !bypass;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q    <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ls_q      <= 1'b0;
      wt_addr_q <= '0;
      wt_data_q <= '0;
    end else begin
      live_q  <= 1'b1;
      count_q <= count_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (pop) begin
        ls_q      <= 1'b1;
        wt_addr_q <= addr_q[head_q];
        wt_data_q <= data_q[head_q];
      end else if (bypass) begin
        ls_q      <= 1'b1;
        wt_addr_q <= in_addr;
        wt_data_q <= in_data;
      end else begin
        ls_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  logic [PW-1:0] idx;

  // Scan oldest to newest so later matches override; output register is the oldest candidate
  always_comb begin
    fwd_hit_A  = 1'b0;
    fwd_data_A = '0;
    fwd_hit_B  = 1'b0;
    fwd_data_B = '0;
    idx        = '0;
    if (ls_q && wt_addr_q == fwd_addr_A) begin
      fwd_hit_A  = 1'b1;
      fwd_data_A = wt_data_q;
    end
    if (ls_q && wt_addr_q == fwd_addr_B) begin
      fwd_hit_B  = 1'b1;
      fwd_data_B = wt_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == fwd_addr_A) begin
          fwd_hit_A  = 1'b1;
          fwd_data_A = data_q[idx];
        end
        if (addr_q[idx] == fwd_addr_B) begin
          fwd_hit_B  = 1'b1;
          fwd_data_B = data_q[idx];
        end
      end
    end
    if (fwd_addr_A == '0) begin
      fwd_hit_A  = 1'b0;
      fwd_data_A = '0;
    end
    if (fwd_addr_B == '0) begin
      fwd_hit_B  = 1'b0;
      fwd_data_B = '0;
    end
  end

  assign L_S     = ls_q;
  assign Wt_addr = wt_addr_q;
  assign Wt_data = wt_data_q;
  assign count   = count_q;
  assign busy    = (count_q != '0) || ls_q;

endmodule

// File: tb/tb_regs_wb_queue.sv
// Bench for regs_wb_queue: directed scenarios plus random traffic against a queue-based model.
module tb_regs_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst, in_valid, in_ready, wb_en, L_S;
  logic [AW-1:0] in_addr, Wt_addr, fwd_addr_A, fwd_addr_B;
  logic [DW-1:0] in_data, Wt_data, fwd_data_A, fwd_data_B;
  logic          fwd_hit_A, fwd_hit_B, busy;
  logic [2:0]    count;

  regs_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_en(wb_en), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .fwd_addr_A(fwd_addr_A), .fwd_hit_A(fwd_hit_A), .fwd_data_A(fwd_data_A),
    .fwd_addr_B(fwd_addr_B), .fwd_hit_B(fwd_hit_B), .fwd_data_B(fwd_data_B),
    .count(count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            m_live, m_ls;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int            n_chk, n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Newest pending value for an address: scan queue newest-first, then the write register
  function automatic logic [DW:0] m_fwd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) return {1'b1, q[i].d};
    if (m_ls && m_wa == a) return {1'b1, m_wd};
    return '0;
  endfunction

  function automatic void m_clear();
    q.delete();
    m_live = 0;
    m_ls   = 0;
    m_wa   = '0;
    m_wd   = '0;
  endfunction

  function automatic void m_edge();
    bit   rdy, keep, byp;
    ent_t e;
    rdy  = m_live && (q.size() < DEPTH);
    keep = in_valid && rdy && (in_addr != '0);
    byp  = 0;
    if (wb_en && q.size() > 0) begin
      e    = q.pop_front();
      m_ls = 1;
      m_wa = e.a;
      m_wd = e.d;
    end else if (BYP && keep && wb_en) begin
      byp  = 1;
      m_ls = 1;
      m_wa = in_addr;
      m_wd = in_data;
    end else begin
      m_ls = 0;
    end
    if (keep && !byp) q.push_back({in_addr, in_data});
    m_live = 1;
  endfunction

  task automatic check_all();
    logic [DW:0] fa, fb;
    fa = m_fwd(fwd_addr_A);
    fb = m_fwd(fwd_addr_B);
    check("in_ready", 64'(in_ready), 64'(m_live && (q.size() < DEPTH)));
    check("count", 64'(count), 64'(q.size()));
    check("L_S", 64'(L_S), 64'(m_ls));
    check("Wt_addr", 64'(Wt_addr), 64'(m_wa));
    check("Wt_data", 64'(Wt_data), 64'(m_wd));
    check("busy", 64'(busy), 64'((q.size() != 0) || m_ls));
    check("fwd_hit_A", 64'(fwd_hit_A), 64'(fa[DW]));
    check("fwd_data_A", 64'(fwd_data_A), 64'(fa[DW-1:0]));
    check("fwd_hit_B", 64'(fwd_hit_B), 64'(fb[DW]));
    check("fwd_data_B", 64'(fwd_data_B), 64'(fb[DW-1:0]));
  endtask

  // Called just after a falling edge: drive, check, clock, advance model, return at next falling edge
  task automatic step(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit wb, input logic [AW-1:0] fa, input logic [AW-1:0] fb);
    in_valid   = v;
    in_addr    = a;
    in_data    = d;
    wb_en      = wb;
    fwd_addr_A = fa;
    fwd_addr_B = fb;
    #1;
    check_all();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    m_clear();
    check("rst_L_S", 64'(L_S), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_Wt_addr", 64'(Wt_addr), 64'(0));
    check("rst_Wt_data", 64'(Wt_data), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int wb_pct;
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    in_valid = 0; in_addr = '0; in_data = '0; wb_en = 0;
    fwd_addr_A = '0; fwd_addr_B = '0;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    check("por_L_S", 64'(L_S), 64'(0));
    check("por_count", 64'(count), 64'(0));
    check("por_in_ready", 64'(in_ready), 64'(0));
    check("por_Wt_addr", 64'(Wt_addr), 64'(0));
    check("por_Wt_data", 64'(Wt_data), 64'(0));
    check("por_busy", 64'(busy), 64'(0));
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // single write with forwarding until the write lands
    step(1, 5, 32'hDEADBEEF, 1, 5, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 5, 5);

    // fill to full, stalled fifth push, then drain
    for (int i = 1; i <= 4; i++) step(1, AW'(i), 32'(i * 32'h101), 0, AW'(i), 0);
    step(1, 6, 32'h66, 0, 6, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, AW'(i), 4);

    // newest wins, zero-address discard
    step(1, 7, 32'h11, 0, 0, 7);
    step(1, 7, 32'h22, 0, 0, 7);
    step(1, 0, 32'h55, 0, 0, 7);
    step(0, 0, 0, 0, 0, 7);

    // simultaneous push and pop
    step(1, 9, 32'h99, 1, 9, 7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 9, 7);

    // reset in the middle of a drain
    for (int i = 1; i <= 3; i++) step(1, AW'(10 + i), 32'(i), 0, 12, 13);
    step(0, 0, 0, 1, 11, 12);
    mid_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 11, 12);

    // random traffic in phases of differing drain pressure
    for (int ph = 0; ph < 12; ph++) begin
      wb_pct = (ph % 3 == 0) ? 15 : (ph % 3 == 1) ? 85 : 50;
      for (int c = 0; c < 250; c++) begin
        step($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 99) < wb_pct,
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        if ($urandom_range(0, 299) == 0) mid_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
